// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port among NUM_REQ producers.
// A grant holds until the owner's last beat or MAX_BURST beats, then one IDLE cycle re-arbitrates.

module fifo_rr_write_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic                  fifo_full,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  xfer,
  output logic                  last_xfer,
  output logic [DATA_WIDTH-1:0] data_out
);
  assign ready     = sel & ~fifo_full;
  assign xfer      = ready & valid;
  assign last_xfer = xfer & last;
  assign data_out  = sel ? data : '0;
endmodule

module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST+1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] rr_last;
  logic [CW-1:0]  beat_cnt;

  logic [NUM_REQ-1:0]                 sel, lane_xfer, lane_last;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
  logic                               xfer, last_hit, found;
  logic [IDW-1:0]                     winner;
  int                                 idx;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      // Outputs collapse to zero while rst_n is low, independent of stale state.
      assign sel[i] = rst_n && (state == S_BURST) && (owner_q == IDW'(i));
      fifo_rr_write_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .sel       (sel[i]),
        .fifo_full (fifo_full),
        .valid     (req_valid[i]),
        .last      (req_last[i]),
        .data      (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
        .ready     (req_ready[i]),
        .xfer      (lane_xfer[i]),
        .last_xfer (lane_last[i]),
        .data_out  (lane_data[i])
      );
    end
  endgenerate

  assign xfer      = |lane_xfer;
  assign last_hit  = |lane_last;
  assign fifo_w_en = xfer;
  assign busy      = rst_n && (state == S_BURST);
  assign owner_id  = rst_n ? owner_q : '0;

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_wdata = fifo_wdata | lane_data[i];
  end

  // Rotating priority: first valid requester after the previous owner wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner_q  <= '0;
      rr_last  <= IDW'(NUM_REQ-1);
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_BURST;
            owner_q  <= winner;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (xfer) begin
            if (last_hit || beat_cnt == CW'(MAX_BURST-1)) begin
              state    <= S_IDLE;
              rr_last  <= owner_q;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter: queue-driven producers, a grant-level
// reference model compared every cycle, and literal checks on the logged writes/grants.

module tb_fifo_rr_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_last = '0;
  logic [NR*DW-1:0]    req_data = '0;
  logic [NR-1:0]       req_ready;
  logic                fifo_full = 1'b0;
  logic                fifo_w_en;
  logic [DW-1:0]       fifo_wdata;
  logic [1:0]          owner_id;
  logic                busy;

  fifo_rr_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_wdata(fifo_wdata), .owner_id(owner_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producers: each requester streams a preloaded packet, popping on accepted beats.
  logic [DW-1:0] pd [NR][16];
  logic          pl [NR][16];
  int            head [NR];
  int            cnt  [NR];
  logic [NR-1:0] hold = '0;

  task automatic load(input int r, input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++) begin
      pd[r][b] = base + DW'(b);
      pl[r][b] = (b == n-1);
    end
    cnt[r]  = n;
    head[r] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (head[i] < cnt[i]) begin
        req_valid[i]           = !hold[i];
        req_data[i*DW +: DW]   = pd[i][head[i]];
        req_last[i]            = pl[i][head[i]];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin head[i] = 0; cnt[i] = 0; end
    hold = '0;
    fifo_full = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: who owns the port and how many beats it has moved.
  int m_owner = -1;
  int m_prev  = NR-1;
  int m_beats = 0;

  always @(posedge clk) begin
    int w;
    w = -1;
    if (!rst_n) begin
      m_owner <= -1;
      m_prev  <= NR-1;
      m_beats <= 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++)
        if (w < 0 && req_valid[(m_prev+k)%NR]) w = (m_prev+k)%NR;
      m_owner <= w;
      m_beats <= 0;
    end else if (req_valid[m_owner] && !fifo_full) begin
      if (req_last[m_owner] || m_beats+1 == MB) begin
        m_prev  <= m_owner;
        m_owner <= -1;
        m_beats <= 0;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  int gnt_log[$];
  int wr_log[$];
  logic busy_d = 1'b0;

  always @(negedge clk) begin
    logic [NR-1:0] e_ready;
    logic          e_wen;
    logic [DW-1:0] e_wdata;
    logic          e_busy;
    e_ready = '0; e_wen = 1'b0; e_wdata = '0; e_busy = 1'b0;
    if (rst_n && m_owner >= 0) begin
      e_busy = 1'b1;
      e_ready[m_owner] = !fifo_full;
      e_wen = req_valid[m_owner] && !fifo_full;
      e_wdata = req_data[m_owner*DW +: DW];
    end
    chk("req_ready", int'(req_ready), int'(e_ready));
    chk("fifo_w_en", int'(fifo_w_en), int'(e_wen));
    chk("fifo_wdata", int'(fifo_wdata), int'(e_wdata));
    chk("busy", int'(busy), int'(e_busy));
    if (e_busy) chk("owner_id", int'(owner_id), m_owner);
    if (rst_n && fifo_w_en) wr_log.push_back(int'(owner_id)*256 + int'(fifo_wdata));
    if (busy && !busy_d) gnt_log.push_back(int'(owner_id));
    busy_d = busy;
  end

  initial begin
    clear_all();

    // 1: reset with every requester valid, then first grant goes to 0
    for (int i = 0; i < NR; i++) load(i, 1, DW'(8'hE0 + i));
    drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t1_rst_ready", int'(req_ready), 0);
      chk("t1_rst_wen", int'(fifo_w_en), 0);
      chk("t1_rst_busy", int'(busy), 0);
    end
    gnt_log.delete(); wr_log.delete();
    rst_n = 1'b1;
    tick();
    chk("t1_busy", int'(busy), 1);
    chk("t1_owner", int'(owner_id), 0);
    for (int c = 0; c < 10; c++) tick();
    chk("t1_ngnt", gnt_log.size(), 4);
    chk("t1_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // 2: lone requester 2, three-beat packet
    do_reset();
    gnt_log.delete(); wr_log.delete();
    load(2, 3, 8'hA1);
    drive();
    chk("t2_idle_first", int'(busy), 0);
    for (int c = 0; c < 4; c++) tick();
    chk("t2_done_busy", int'(busy), 0);
    chk("t2_nwr", wr_log.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("t2_wr", (k < wr_log.size()) ? wr_log[k] : -1, 2*256 + 8'hA1 + k);

    // 3: all four valid with long packets, bursts capped at MAX_BURST
    do_reset();
    gnt_log.delete(); wr_log.delete();
    for (int i = 0; i < NR; i++) load(i, 6, DW'(16*i));
    drive();
    begin
      int c;
      c = 0;
      while (c < 80 && !(gnt_log.size() >= 5 && wr_log.size() >= 16)) begin
        tick();
        c++;
      end
      if (c >= 80) chk("t3_timeout", c, 0);
    end
    for (int k = 0; k < 5; k++)
      chk("t3_gnt", (k < gnt_log.size()) ? gnt_log[k] : -1, k % NR);
    for (int k = 0; k < 16; k++)
      chk("t3_wr", (k < wr_log.size()) ? wr_log[k] : -1, (k/4)*256 + (k/4)*16 + k%4);
    for (int c = 0; c < 40; c++) tick();

    // 4: FIFO full stall after two beats of requester 1
    do_reset();
    gnt_log.delete(); wr_log.delete();
    load(1, 4, 8'h40);
    drive();
    tick(); tick(); tick();
    fifo_full = 1'b1;
    #1;
    chk("t4_full_wen", int'(fifo_w_en), 0);
    chk("t4_full_ready", int'(req_ready), 0);
    for (int c = 0; c < 5; c++) tick();
    chk("t4_stall_nwr", wr_log.size(), 2);
    fifo_full = 1'b0;
    #1;
    chk("t4_resume_wen", int'(fifo_w_en), 1);
    chk("t4_resume_data", int'(fifo_wdata), 8'h42);
    tick(); tick(); tick();
    chk("t4_nwr", wr_log.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_wr", (k < wr_log.size()) ? wr_log[k] : -1, 256 + 8'h40 + k);

    // 5: owner 3 drops valid mid-packet while requester 0 waits
    do_reset();
    gnt_log.delete(); wr_log.delete();
    load(3, 3, 8'hC0);
    drive();
    tick(); tick();
    load(0, 1, 8'h0A);
    hold[3] = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("t5_hold_busy", int'(busy), 1);
      chk("t5_hold_owner", int'(owner_id), 3);
    end
    hold[3] = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) tick();
    chk("t5_ngnt", gnt_log.size(), 2);
    chk("t5_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 3);
    chk("t5_gnt1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 0);
    for (int k = 0; k < 3; k++)
      chk("t5_wr", (k < wr_log.size()) ? wr_log[k] : -1, 3*256 + 8'hC0 + k);
    chk("t5_wr3", (wr_log.size() > 3) ? wr_log[3] : -1, 8'h0A);

    // 6: reset during the second beat of a burst
    do_reset();
    gnt_log.delete(); wr_log.delete();
    load(2, 4, 8'h80);
    drive();
    tick(); tick();
    rst_n = 1'b0;
    load(0, 1, 8'h0B);
    drive();
    #1;
    chk("t6_rst_wen", int'(fifo_w_en), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_ready", int'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_regrant_busy", int'(busy), 1);
    chk("t6_regrant_owner", int'(owner_id), 0);
    for (int c = 0; c < 8; c++) tick();
    chk("t6_nwr", wr_log.size(), 5);
    chk("t6_wr0", (wr_log.size() > 0) ? wr_log[0] : -1, 2*256 + 8'h80);
    chk("t6_wr1", (wr_log.size() > 1) ? wr_log[1] : -1, 8'h0B);
    chk("t6_wr2", (wr_log.size() > 2) ? wr_log[2] : -1, 2*256 + 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
